// File: rtl/config_byte_packer.sv
// Packs a received byte stream into 32-bit big-endian words and tracks session activity.
// Optional CFG_PACKER_REALIGN_EN realigns the word boundary on the FAB0_FAB1 sync pattern.
module config_byte_packer #(
    parameter int unsigned IdleTimeout      = 4096,
    parameter int unsigned IdleCounterWidth = 13
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic [31:0] WriteData,
    output logic        WriteStrobe,
    output logic        ComActive,
    output logic [1:0]  ByteIndex
);

    typedef enum logic {StIdle, StActive} state_e;

    localparam logic [IdleCounterWidth-1:0] ExpireCount = IdleCounterWidth'(IdleTimeout - 1);

    state_e                      state_q;
    logic [31:0]                 asm_q;
    logic [IdleCounterWidth-1:0] idle_cnt_q;
    logic [31:0]                 shifted;
    logic                        word_done;

    assign shifted = {asm_q[23:0], RxData};

`ifdef CFG_PACKER_REALIGN_EN
    localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;
    // A sync match at any byte position closes the word, so it also covers normal completion.
    assign word_done = RxValid && ((ByteIndex == 2'd3) || (shifted == SyncWord));
`else
    assign word_done = RxValid && (ByteIndex == 2'd3);
`endif

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q     <= StIdle;
            asm_q       <= '0;
            idle_cnt_q  <= '0;
            WriteData   <= '0;
            WriteStrobe <= 1'b0;
            ComActive   <= 1'b0;
            ByteIndex   <= 2'd0;
        end else begin
            WriteStrobe <= 1'b0;
            if (RxValid) begin
                // A byte always wins over an expiring idle counter.
                state_q    <= StActive;
                ComActive  <= 1'b1;
                asm_q      <= shifted;
                idle_cnt_q <= '0;
                if (word_done) begin
                    WriteData   <= shifted;
                    WriteStrobe <= 1'b1;
                    ByteIndex   <= 2'd0;
                end else begin
                    ByteIndex <= ByteIndex + 2'd1;
                end
            end else if (state_q == StActive) begin
                if (idle_cnt_q == ExpireCount) begin
                    state_q    <= StIdle;
                    ComActive  <= 1'b0;
                    ByteIndex  <= 2'd0;
                    asm_q      <= '0;
                    idle_cnt_q <= '0;
                end else begin
                    idle_cnt_q <= idle_cnt_q + IdleCounterWidth'(1);
                end
            end
        end
    end

endmodule
